// File: rtl/sha256_round_core.sv
// ---------------------------------------------------------------------------
// sha256_round_core
//
// Purpose:
//   SHA-256 compression engine that applies one round per schedule word
//   received from an upstream message-schedule stage. A block starts from a
//   chaining value, consumes W_LENGTH words in strict round order and then
//   emits the updated chaining value for one cycle.
//
// Ports:
//   clock      in   1    rising-edge clock for all state
//   reset      in   1    asynchronous, active-low reset
//   start      in   1    one-cycle request to begin a new block (IDLE only)
//   h_in       in   256  chaining value H0..H7, H0 in [255:224]
//   w_valid    in   1    qualifies cur_w / w_index
//   cur_w      in   32   schedule word Wt
//   w_index    in   clog2(W_LENGTH)  round number t of cur_w
//   busy       out  1    high whenever the engine is not idle
//   hash_valid out  1    one-cycle pulse marking a new hash_out
//   hash_out   out  256  updated chaining value, H0 in [255:224]
//   seq_error  out  1    sticky flag: a word arrived out of order
// ---------------------------------------------------------------------------
module sha256_round_core #(
  parameter int W_LENGTH = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [255:0]                h_in,
  input  logic                        w_valid,
  input  logic [31:0]                 cur_w,
  input  logic [$clog2(W_LENGTH)-1:0] w_index,
  output logic                        busy,
  output logic                        hash_valid,
  output logic [255:0]                hash_out,
  output logic                        seq_error
);

  localparam int IDX_W = $clog2(W_LENGTH);
  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(W_LENGTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;

  // SHA-256 round constants K[0..63]
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] roundCnt_q, roundCnt_d;
  logic [255:0]     chain_q, chain_d;
  logic [255:0]     work_q, work_d;
  logic [255:0]     hashOut_q, hashOut_d;
  logic             seqErr_q, seqErr_d;

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] sigma0, sigma1, choose, majority, kWord, t1, t2, newA, newE;
  logic [5:0]  kIdx;
  logic        wordHit;

  // Working variables a..h are packed with a in the top word, same layout as H.
  assign {a, b, c, d, e, f, g, h} = work_q;

  // One SHA-256 round on the current working variables and the offered word.
  always_comb begin
    kIdx     = 6'(roundCnt_q);
    kWord    = K[kIdx];
    sigma1   = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    sigma0   = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    choose   = (e & f) ^ (~e & g);
    majority = (a & b) ^ (a & c) ^ (b & c);
    t1       = h + sigma1 + choose + kWord + cur_w;
    t2       = sigma0 + majority;
    newA     = t1 + t2;
    newE     = d + t1;
  end

  // A word counts only when it is the one the round counter is waiting for.
  assign wordHit = w_valid && (w_index == roundCnt_q);

  // Next-state logic. The final hash is formed on the same edge that consumes
  // the last word, so hash_out is already valid while hash_valid is high.
  always_comb begin
    state_d    = state_q;
    roundCnt_d = roundCnt_q;
    chain_d    = chain_q;
    work_d     = work_q;
    hashOut_d  = hashOut_q;
    seqErr_d   = seqErr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          chain_d    = h_in;
          work_d     = h_in;
          roundCnt_d = '0;
          seqErr_d   = 1'b0;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        if (wordHit) begin
          work_d = {newA, a, b, c, newE, e, f, g};
          if (roundCnt_q == LAST_T) begin
            hashOut_d = {chain_q[255:224] + newA, chain_q[223:192] + a,
                         chain_q[191:160] + b,    chain_q[159:128] + c,
                         chain_q[127:96]  + newE, chain_q[95:64]   + e,
                         chain_q[63:32]   + f,    chain_q[31:0]    + g};
            state_d   = FINAL;
          end else begin
            roundCnt_d = roundCnt_q + 1'b1;
          end
        end else if (w_valid) begin
          seqErr_d = 1'b1;
        end
      end
      FINAL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      roundCnt_q <= '0;
      chain_q    <= '0;
      work_q     <= '0;
      hashOut_q  <= '0;
      seqErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      roundCnt_q <= roundCnt_d;
      chain_q    <= chain_d;
      work_q     <= work_d;
      hashOut_q  <= hashOut_d;
      seqErr_q   <= seqErr_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign hash_valid = (state_q == FINAL);
  assign hash_out   = hashOut_q;
  assign seq_error  = seqErr_q;

endmodule

// File: tb/tb_sha256_round_core.sv
// ---------------------------------------------------------------------------
// tb_sha256_round_core
//
// Purpose:
//   Self-checking bench for sha256_round_core. The bench expands message
//   blocks into schedule words itself, streams them into the core and keeps
//   a block-level reference of what the outputs must be. Known SHA-256
//   digests pin the reference.
// ---------------------------------------------------------------------------
module tb_sha256_round_core;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIGEST = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                         32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] TWO_BLOCK_DIGEST = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                               32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] LONG_BLOCK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] LONG_BLOCK2 = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clock = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [255:0] h_in = '0;
  logic         w_valid = 1'b0;
  logic [31:0]  cur_w = '0;
  logic [5:0]   w_index = '0;
  logic         busy;
  logic         hash_valid;
  logic [255:0] hash_out;
  logic         seq_error;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int startCycle = 0;
  logic [31:0] schedW [64];

  sha256_round_core #(.W_LENGTH(64)) dut (
    .clock(clock), .reset(rst_n), .start(start), .h_in(h_in),
    .w_valid(w_valid), .cur_w(cur_w), .w_index(w_index),
    .busy(busy), .hash_valid(hash_valid), .hash_out(hash_out), .seq_error(seq_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  function automatic void checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight SHA-256 compression of one block from a chaining value.
  function automatic logic [255:0] compress(input logic [255:0] hv, input logic [31:0] w [64]);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [255:0] finishBlock(input logic [255:0] hv, input logic [31:0] w [64],
                                               input logic [31:0] lastW);
    logic [31:0] full [64];
    full = w;
    full[63] = lastW;
    return compress(hv, full);
  endfunction

  // Upstream message schedule expansion, producing the words the core consumes.
  task automatic buildSchedule(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) schedW[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(schedW[t-15], 7) ^ rotr(schedW[t-15], 18) ^ (schedW[t-15] >> 3);
      s1 = rotr(schedW[t-2], 17) ^ rotr(schedW[t-2], 19) ^ (schedW[t-2] >> 10);
      schedW[t] = s1 + schedW[t-7] + s0 + schedW[t-16];
    end
  endtask

  // Reference: phase 0 = idle, 1 = collecting words, 2 = result cycle.
  int           mPhase = 0;
  int           mCount = 0;
  logic         mSeqErr = 1'b0;
  logic [255:0] mChain = '0;
  logic [255:0] mHash = '0;
  logic [31:0]  mWords [64];

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mPhase  <= 0;
      mCount  <= 0;
      mSeqErr <= 1'b0;
      mChain  <= '0;
      mHash   <= '0;
    end else begin
      case (mPhase)
        0: if (start) begin
          mChain  <= h_in;
          mCount  <= 0;
          mSeqErr <= 1'b0;
          mPhase  <= 1;
        end
        1: if (w_valid) begin
          if (int'(w_index) == mCount) begin
            mWords[mCount] <= cur_w;
            if (mCount == 63) begin
              mHash  <= finishBlock(mChain, mWords, cur_w);
              mPhase <= 2;
            end else begin
              mCount <= mCount + 1;
            end
          end else begin
            mSeqErr <= 1'b1;
          end
        end
        default: mPhase <= 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the reference on the falling edge.
  always @(negedge clock) begin
    checkOutput("busy", {255'b0, busy}, {255'b0, mPhase != 0});
    checkOutput("hash_valid", {255'b0, hash_valid}, {255'b0, mPhase == 2});
    checkOutput("seq_error", {255'b0, seq_error}, {255'b0, mSeqErr});
    checkOutput("hash_out", hash_out, mHash);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic startBlock(input logic [255:0] hv);
    start = 1'b1;
    h_in = hv;
    startCycle = cycleCnt;
    tick();
    start = 1'b0;
  endtask

  // Streams words first..last; optional idle cycle before each word and an
  // optional stray start pulse alongside word interfereAt.
  task automatic applyStimulus(input int first, input int last, input bit gaps, input int interfereAt);
    for (int t = first; t <= last; t++) begin
      if (gaps) begin
        w_valid = 1'b0;
        w_index = 6'($urandom_range(63));
        cur_w = $urandom;
        tick();
      end
      w_valid = 1'b1;
      w_index = 6'(t);
      cur_w = schedW[t];
      if (t == interfereAt) begin
        start = 1'b1;
        h_in = {8{32'hdeadbeef}};
      end
      tick();
      start = 1'b0;
    end
    w_valid = 1'b0;
  endtask

  // Waits (bounded) for hash_valid; latency counts the start cycle as cycle 1.
  task automatic waitValid(input string name, input int expLat);
    int lat = -1;
    for (int i = 0; i < 300; i++) begin
      if (hash_valid === 1'b1) begin
        lat = cycleCnt - startCycle + 1;
        break;
      end
      tick();
    end
    checkOutput({name, " latency"}, 256'(lat), 256'(expLat));
  endtask

  initial begin
    int seen;
    logic [255:0] firstHash;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset busy", {255'b0, busy}, 256'd0);
    checkOutput("reset hash_out", hash_out, 256'd0);
    @(negedge clock);
    rst_n = 1'b1;
    tick();

    // Pin the reference on the "abc" digest
    buildSchedule(ABC_BLOCK);
    checkOutput("reference abc", compress(IV, schedW), ABC_DIGEST);

    // Back-to-back "abc"
    $display("[TB] abc back-to-back");
    startBlock(IV);
    applyStimulus(0, 63, 1'b0, -1);
    waitValid("abc", 66);
    checkOutput("abc digest", hash_out, ABC_DIGEST);
    tick();

    // Alternate-cycle stalls
    $display("[TB] abc with stalls");
    startBlock(IV);
    applyStimulus(0, 63, 1'b1, -1);
    waitValid("abc stalled", 130);
    checkOutput("abc stalled digest", hash_out, ABC_DIGEST);
    tick();

    // Out-of-order word at round 3
    $display("[TB] out-of-order word");
    startBlock(IV);
    applyStimulus(0, 2, 1'b0, -1);
    w_valid = 1'b1;
    w_index = 6'd5;
    cur_w = 32'h12345678;
    tick();
    w_valid = 1'b0;
    checkOutput("seq_error set", {255'b0, seq_error}, 256'd1);
    checkOutput("busy after bad word", {255'b0, busy}, 256'd1);
    applyStimulus(3, 63, 1'b0, -1);
    waitValid("seq", 67);
    checkOutput("seq digest", hash_out, ABC_DIGEST);
    tick();
    checkOutput("seq_error sticky", {255'b0, seq_error}, 256'd1);

    // Reset at round 30
    $display("[TB] reset mid-block");
    startBlock(IV);
    applyStimulus(0, 29, 1'b0, -1);
    w_valid = 1'b1;
    w_index = 6'd30;
    cur_w = schedW[30];
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {255'b0, busy}, 256'd0);
    checkOutput("abort hash_out", hash_out, 256'd0);
    checkOutput("abort seq_error", {255'b0, seq_error}, 256'd0);
    checkOutput("abort hash_valid", {255'b0, hash_valid}, 256'd0);
    w_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    tick();
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (hash_valid === 1'b1) seen++;
      tick();
    end
    checkOutput("no valid after abort", 256'(seen), 256'd0);
    startBlock(IV);
    applyStimulus(0, 63, 1'b0, -1);
    waitValid("post-reset", 66);
    checkOutput("post-reset digest", hash_out, ABC_DIGEST);
    tick();

    // Stray starts while busy and in the hash_valid cycle
    $display("[TB] ignored starts");
    startBlock(IV);
    applyStimulus(0, 63, 1'b0, 10);
    waitValid("interfered", 66);
    checkOutput("interfered digest", hash_out, ABC_DIGEST);
    start = 1'b1;
    h_in = {8{32'hcafef00d}};
    tick();
    start = 1'b0;
    checkOutput("busy after final", {255'b0, busy}, 256'd0);
    tick();
    checkOutput("still idle", {255'b0, busy}, 256'd0);

    // Two chained blocks of the 448-bit test message
    $display("[TB] chained blocks");
    buildSchedule(LONG_BLOCK1);
    firstHash = compress(IV, schedW);
    startBlock(IV);
    applyStimulus(0, 63, 1'b0, -1);
    waitValid("chain block1", 66);
    checkOutput("chain block1", hash_out, firstHash);
    tick();
    buildSchedule(LONG_BLOCK2);
    checkOutput("reference two-block", compress(firstHash, schedW), TWO_BLOCK_DIGEST);
    startBlock(hash_out);
    applyStimulus(0, 40, 1'b0, -1);
    checkOutput("chain hold", hash_out, firstHash);
    applyStimulus(41, 63, 1'b0, -1);
    waitValid("chain block2", 66);
    checkOutput("chain digest", hash_out, TWO_BLOCK_DIGEST);
    tick();
    tick();
    checkOutput("final hold", hash_out, TWO_BLOCK_DIGEST);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_round_core.md
SHA256_ROUND_CORE -- requirements
Module: sha256_round_core

Interface
REQ-001 Parameter W_LENGTH, default 64, SHALL set the number of compression rounds per block.
REQ-002 clock  input  1  SHALL be the single rising-edge clock for all state.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be a one-cycle request to begin compressing a new 512-bit block.
REQ-005 h_in  input  256  SHALL carry the chaining value H0..H7, with H0 in [255:224].
REQ-006 w_valid  input  1  SHALL qualify cur_w and w_index in the same cycle.
REQ-007 cur_w  input  32  SHALL be the schedule word Wt from the upstream message-schedule stage.
REQ-008 w_index  input  $clog2(W_LENGTH)  SHALL be the round number t of cur_w.
REQ-009 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-010 hash_valid  output  1  SHALL be a one-cycle pulse marking a new hash_out.
REQ-011 hash_out  output  256  SHALL carry the updated chaining value, with H0 in [255:224].
REQ-012 seq_error  output  1  SHALL be a sticky flag for an out-of-order schedule word.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ROUND and FINAL.
REQ-014 In IDLE, start SHALL latch h_in into H0..H7 and into working registers a..h, clear the round counter, clear seq_error, and move the FSM to ROUND on the next edge.
REQ-015 In ROUND, a word SHALL be accepted only when w_valid=1 and w_index equals the round counter.
- One round is applied per accepted word.
- Gaps in w_valid SHALL stall the FSM with no state change.
REQ-016 Each round SHALL compute the following, with all additions mod 2^32:
- T1 = h + S1(e) + Ch(e,f,g) + K[t] + Wt
- T2 = S0(a) + Maj(a,b,c)
- Update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
REQ-017 The round functions SHALL be defined as:
- S1(e) = ROTR6 ^ ROTR11 ^ ROTR25
- S0(a) = ROTR2 ^ ROTR13 ^ ROTR22
- Ch = (e&f) ^ (~e&g)
- Maj = (a&b) ^ (a&c) ^ (b&c)
REQ-018 K[0..63] SHALL be the FIPS 180-4 SHA-256 constants, held in an internal constant table.
REQ-019 When w_valid=1 and w_index differs from the round counter in ROUND, the word SHALL be ignored and seq_error SHALL be set.
- seq_error stays set until the next accepted start or reset.
REQ-020 After the word with t=W_LENGTH-1 is accepted, the FSM SHALL enter FINAL.
REQ-021 In FINAL, hash_out SHALL be loaded with {H0+a, ..., H7+h}, each sum mod 2^32.
- hash_valid SHALL pulse for exactly one cycle.
- The FSM SHALL return to IDLE on the next edge.
REQ-022 Latency SHALL be one cycle from the last accepted word to FINAL, and hash_valid SHALL be high during FINAL.
- With back-to-back words the total is 1 (load) + 64 + 1 = 66 cycles from start to hash_valid.
REQ-023 hash_out SHALL hold its value until the next FINAL.
REQ-024 start SHALL be ignored in ROUND and FINAL.
REQ-025 w_valid SHALL be ignored in IDLE and FINAL.
REQ-026 A start coincident with the hash_valid cycle SHALL be ignored, and upstream SHALL reassert start in IDLE.
REQ-027 The round counter SHALL never wrap, because the FSM leaves ROUND at t=W_LENGTH-1.

Reset
REQ-028 Assertion of reset SHALL, without waiting for a clock edge:
- force the FSM to IDLE
- clear busy, hash_valid, seq_error, hash_out, H0..H7, a..h and the round counter to 0
REQ-029 Reset asserted mid-block SHALL abandon the block, and no hash_valid SHALL follow.
REQ-030 After deassertion, the first start SHALL behave as in REQ-014.

Verification
REQ-031 Load the standard IV, then stream the 64 schedule words of the padded "abc" block at t=0..63, one per cycle -> hash_valid pulses 66 cycles after start, with hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-032 Same stimulus with w_valid low on alternate cycles -> identical hash_out, with hash_valid delayed by the number of stall cycles.
REQ-033 Present w_index=5 when the counter is 3 -> seq_error=1, counter stays at 3, and a..h are unchanged.
REQ-034 Assert reset at round 30 -> all outputs are 0 at once; no hash_valid follows; a fresh "abc" run then matches REQ-031.
REQ-035 Pulse start while busy=1 and also in the hash_valid cycle -> both are ignored; the current block completes normally and busy=0 afterwards.
REQ-036 Chain two blocks by feeding the first hash_out back as h_in -> the second result matches the software model, and hash_out holds between the two pulses.
